// File: rtl/send_port_arbiter.sv
// Packet-aware round-robin arbiter sharing one send port between NUM_REQ flit sources.
// Define ARB_PACKET_LOCK_EN to hold the grant across multi-flit packets; otherwise arbitration is per flit.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module send_port_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = `FLIT_WIDTH,
  parameter int unsigned TAIL_BIT   = `FLIT_WIDTH - 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         put_flit,
  output logic                          put_flit_valid,
  input  logic                          put_flit_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        owner_q, owner_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [IDW-1:0]        grant_q, grant_d;

  logic                  win_valid_c;
  logic [IDW-1:0]        win_id_c;
  logic [DATA_WIDTH-1:0] win_flit_c;
  logic                  load_c;

  // Winner selection: the owner alone while locked, else first valid from rr_ptr upward.
  always_comb begin
    win_valid_c = 1'b0;
    win_id_c    = '0;
    if (state_q == LOCKED) begin
      win_valid_c = req_valid[owner_q];
      win_id_c    = owner_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        automatic int unsigned idx  = 32'(rr_ptr_q) + k;
        automatic logic [IDW-1:0] cand;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = IDW'(idx);
        if (!win_valid_c && req_valid[cand]) begin
          win_valid_c = 1'b1;
          win_id_c    = cand;
        end
      end
    end
  end

  assign win_flit_c = req_flit[32'(win_id_c)*DATA_WIDTH +: DATA_WIDTH];
  assign load_c     = RST_N && win_valid_c && (!out_valid_q || put_flit_ready);
  assign req_ready  = load_c ? (NUM_REQ'(1) << win_id_c) : '0;

  // State register and output stage
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
    end
  end

`ifdef ARB_PACKET_LOCK_EN
  logic win_tail_c;
  assign win_tail_c = win_flit_c[TAIL_BIT];
`endif

  // Next state: lock on a non-tail head, release on tail; the pointer only moves from IDLE.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (load_c) begin
`ifdef ARB_PACKET_LOCK_EN
      if (state_q == IDLE) begin
        rr_ptr_d = (32'(win_id_c) == NUM_REQ - 1) ? '0 : win_id_c + IDW'(1);
        if (!win_tail_c) begin
          state_d = LOCKED;
          owner_d = win_id_c;
        end
      end else if (win_tail_c) begin
        state_d = IDLE;
      end
`else
      rr_ptr_d = (32'(win_id_c) == NUM_REQ - 1) ? '0 : win_id_c + IDW'(1);
`endif
    end
  end

  // Output stage: reload on load (drain and refill in one cycle), else drain when accepted.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    if (load_c) begin
      out_data_d  = win_flit_c;
      out_valid_d = 1'b1;
      grant_d     = win_id_c;
    end else if (put_flit_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  assign put_flit       = out_data_q;
  assign put_flit_valid = out_valid_q;
  assign grant_id       = grant_q;
`ifdef ARB_PACKET_LOCK_EN
  assign locked = (state_q == LOCKED);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_send_port_arbiter.sv
// Self-checking bench for send_port_arbiter: queue-fed sources, a spec-level model checked
// every cycle, and directed scenarios with literal grant orders for both lock configurations.
module tb_send_port_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned N3   = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned TBIT = 14;
`ifdef ARB_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*DW-1:0] req_flit;
  logic [N-1:0]    req_valid, req_ready;
  logic [DW-1:0]   put_flit;
  logic            put_flit_valid, put_flit_ready;
  logic [1:0]      grant_id;
  logic            locked;

  logic [N3*DW-1:0] req_flit3;
  logic [N3-1:0]    req_valid3, req_ready3;
  logic [DW-1:0]    put_flit3;
  logic             put_flit_valid3, put_flit_ready3;
  logic [1:0]       grant_id3;
  logic             locked3;

  send_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAIL_BIT(TBIT)) u_dut (
    .CLK(clk), .RST_N(rst_n), .req_flit(req_flit), .req_valid(req_valid), .req_ready(req_ready),
    .put_flit(put_flit), .put_flit_valid(put_flit_valid), .put_flit_ready(put_flit_ready),
    .grant_id(grant_id), .locked(locked));

  send_port_arbiter #(.NUM_REQ(N3), .DATA_WIDTH(DW), .TAIL_BIT(TBIT)) u_dut3 (
    .CLK(clk), .RST_N(rst_n), .req_flit(req_flit3), .req_valid(req_valid3), .req_ready(req_ready3),
    .put_flit(put_flit3), .put_flit_valid(put_flit_valid3), .put_flit_ready(put_flit_ready3),
    .grant_id(grant_id3), .locked(locked3));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int id, input int seq, input bit tail);
    return {1'b1, tail, 2'b00, 4'(id), 8'(seq)};
  endfunction

  // Per-requester flit lists; a source is valid while enabled and not exhausted.
  logic [DW-1:0] src_flit [N][32];
  int src_len [N] = '{default:0};
  int idx [N] = '{default:0};
  logic [N-1:0] en = '0;

  always_comb begin
    req_flit  = '0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (idx[i] < src_len[i]);
      req_flit[i*DW +: DW] = (idx[i] < 32) ? src_flit[i][idx[i]] : '0;
    end
  end

  int log_id [64];
  int log_n = 0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        idx[i] <= idx[i] + 1;
        if (log_n < 64) log_id[log_n] <= i;
      end
    if (|(req_valid & req_ready)) log_n <= log_n + 1;
  end

  // Behavioural model, instance 0 = 4 requesters, instance 1 = 3 requesters.
  logic          m_locked [2];
  int            m_owner [2], m_ptr [2], m_grant [2];
  logic          m_ov [2];
  logic [DW-1:0] m_od [2];

  function automatic int pick(input int n, input logic [3:0] v, input logic lk, input int own, input int ptr);
    if (lk) return v[own] ? own : -1;
    for (int k = 0; k < n; k++)
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(input int j, input logic [3:0] v, input logic pr);
    int w;
    w = pick(j == 0 ? N : N3, v, m_locked[j], m_owner[j], m_ptr[j]);
    if (!rst_n || w < 0 || (m_ov[j] && !pr)) return 4'b0000;
    return 4'(1) << w;
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      automatic int n = (j == 0) ? N : N3;
      automatic logic [3:0] v = (j == 0) ? req_valid : {1'b0, req_valid3};
      automatic logic pr = (j == 0) ? put_flit_ready : put_flit_ready3;
      automatic int w = pick(n, v, m_locked[j], m_owner[j], m_ptr[j]);
      automatic logic [DW-1:0] f = '0;
      if (!rst_n) begin
        m_locked[j] <= 1'b0; m_owner[j] <= 0; m_ptr[j] <= 0; m_grant[j] <= 0;
        m_ov[j] <= 1'b0; m_od[j] <= '0;
      end else if (w >= 0 && (!m_ov[j] || pr)) begin
        f = (j == 0) ? req_flit[w*DW +: DW] : req_flit3[w*DW +: DW];
        m_od[j] <= f; m_ov[j] <= 1'b1; m_grant[j] <= w;
        if (!LOCK_EN) m_ptr[j] <= (w + 1) % n;
        else if (!m_locked[j]) begin
          m_ptr[j] <= (w + 1) % n;
          if (!f[TBIT]) begin m_locked[j] <= 1'b1; m_owner[j] <= w; end
        end else if (f[TBIT]) m_locked[j] <= 1'b0;
      end else if (pr && m_ov[j]) begin
        m_ov[j] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", req_ready, exp_rdy(0, req_valid, put_flit_ready));
      chk("out_valid", put_flit_valid, m_ov[0]);
      chk("out_data", put_flit, m_od[0]);
      chk("grant_id", grant_id, m_grant[0]);
      chk("locked", locked, m_locked[0]);
      chk("ready3", req_ready3, exp_rdy(1, {1'b0, req_valid3}, put_flit_ready3));
      chk("out_valid3", put_flit_valid3, m_ov[1]);
      chk("out_data3", put_flit3, m_od[1]);
      chk("grant_id3", grant_id3, m_grant[1]);
      chk("locked3", locked3, m_locked[1]);
    end
  end

  task automatic push(input int i, input int seq, input bit tail);
    src_flit[i][src_len[i]] = mk(i, seq, tail);
    src_len[i] = src_len[i] + 1;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++)
      if (en[i] && idx[i] < src_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int budget, output int lk_cycles);
    int c;
    c = 0;
    lk_cycles = 0;
    while (!all_done() && c < budget) begin
      @(negedge clk);
      if (locked) lk_cycles++;
      @(posedge clk); #1;
      c++;
    end
    chk("drain_in_budget", all_done(), 1);
  endtask

  task automatic chk_log(input string nm, input int base, input string exp);
    chk({nm, "_count"}, log_n - base, exp.len());
    for (int k = 0; k < exp.len() && base + k < 64; k++)
      chk(nm, log_id[base + k], int'(exp[k]) - 48);
  endtask

  int base, lk, rz, hs;

  initial begin
    put_flit_ready  = 1'b1;
    put_flit_ready3 = 1'b1;
    req_valid3      = '0;
    req_flit3       = {mk(2, 0, 1), mk(1, 0, 1), mk(0, 0, 1)};

    // Single-flit packets from every source, requesters valid during reset.
    push(0, 0, 1); push(0, 1, 1); push(1, 0, 1); push(2, 0, 1); push(3, 0, 1);
    en = 4'b1111;
    step(2);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", put_flit_valid, 0);
    chk("rst_put_flit", put_flit, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = log_n;
    run_until_done(50, lk);
    chk_log("rr_order", base, "01230");

    // Three-flit packet from 2 contending with single flits from 0.
    base = log_n;
    push(2, 0, 0); push(2, 1, 0); push(2, 2, 1); push(0, 2, 1); push(0, 3, 1);
    run_until_done(50, lk);
    chk_log("packet_order", base, LOCK_EN ? "22200" : "20202");
    chk("packet_locked_cycles", lk, LOCK_EN ? 2 : 0);

    // Owner stalls mid-packet for five cycles while the others wait.
    base = log_n;
    en = 4'b0010;
    push(1, 0, 0);
    run_until_done(50, lk);
    push(0, 4, 1); push(2, 3, 1); push(3, 1, 1);
    en = 4'b1111;
    rz = 0; lk = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_ready == '0) rz++;
      if (locked) lk++;
      @(posedge clk); #1;
    end
    chk("stall_no_ready_cycles", rz, LOCK_EN ? 5 : 2);
    chk("stall_locked_cycles", lk, LOCK_EN ? 5 : 0);
    push(1, 1, 0); push(1, 2, 1);
    run_until_done(50, lk);
    chk_log("stall_order", base, LOCK_EN ? "111230" : "123011");

    // Backpressure with the output stage full, then full-rate streaming.
    for (int k = 0; k < 6; k++) push(0, 8 + k, 1);
    en = 4'b0001;
    step(2);
    put_flit_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", put_flit_valid, 1);
      chk("bp_hold", put_flit, mk(0, 9, 1));
      @(posedge clk); #1;
    end
    put_flit_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (req_ready[0] && req_valid[0]) hs++;
      @(posedge clk); #1;
    end
    chk("bp_resume_rate", hs, 3);
    run_until_done(50, lk);

    // Three requesters: grant to 2 wraps the scan back to 0.
    req_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      automatic string ord = "0120";
      @(negedge clk);
      chk("wrap3_ready", req_ready3, 3'(1) << (int'(ord[c]) - 48));
      @(posedge clk); #1;
    end
    req_valid3 = '0;
    step(2);

    // Reset while the output is full (and mid-packet when locking is enabled).
    en = 4'b1000;
    push(3, 1, 0); push(3, 2, 1);
    step(1);
    put_flit_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_locked", locked, LOCK_EN);
    chk("pre_rst_full", put_flit_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    en = 4'b0000;
    step(1);
    rst_n = 1'b1;
    put_flit_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", put_flit_valid, 0);
    chk("post_rst_locked", locked, 0);
    @(posedge clk); #1;
    base = log_n;
    en = 4'b0010;
    push(1, 3, 1);
    run_until_done(50, lk);
    chk_log("post_rst_grant", base, "1");
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/send_port_arbiter.md
# send_port_arbiter

Packet-aware round-robin arbiter that shares one network send port between `NUM_REQ` device-side flit sources. It sits between the device requesters and the single send-side flit FIFO that feeds the router's `putFlit`/credit interface. It holds the grant for a whole multi-flit packet, up to and including the tail flit, so flits from different sources never interleave on the port. It drives the port through a one-entry registered output stage.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2, need not be a power of two.
- `DATA_WIDTH`, `` `FLIT_WIDTH ``: flit width.
- `TAIL_BIT`, `` `FLIT_WIDTH-2 ``: flit bit that marks the tail. 1 = last flit of a packet; a single-flit packet has it set.

Ports:
- `CLK`  in  1  clock.
- `RST_N`  in  1  reset; synchronous, active-low.
- `req_flit`  in  `NUM_REQ*DATA_WIDTH`  flit from requester i, located at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid`  in  `NUM_REQ`  per-requester valid.
- `req_ready`  out  `NUM_REQ`  per-requester ready; at most one bit high per cycle.
- `put_flit`  out  `DATA_WIDTH`  flit toward the send FIFO.
- `put_flit_valid`  out  1  output stage holds a flit.
- `put_flit_ready`  in  1  send FIFO accepts.
- `grant_id`  out  `$clog2(NUM_REQ)`  current or last granted requester.
- `locked`  out  1  arbiter is mid-packet.

## Operation
- **Output stage**: one register pair `out_data`/`out_valid`.
  - `load = win_valid && (!out_valid || put_flit_ready)`.
  - On `load`: `out_data <= winner flit`, `out_valid <= 1`.
  - Else on `put_flit_ready && out_valid`: `out_valid <= 0`.
- **Handshake**: `req_ready[i] = load && (winner == i)`. A transfer on source i is `req_valid[i] && req_ready[i]`.
- **State machine** (state, `owner`, `rr_ptr`):
  - IDLE: the winner is the first i with `req_valid[i]`, scanning `rr_ptr, rr_ptr+1, …` modulo `NUM_REQ`.
    - On `load` with tail=1: stay IDLE.
    - On `load` with tail=0: go to LOCKED, `owner <= winner`.
    - In both cases `rr_ptr <= winner+1` (mod `NUM_REQ`).
  - LOCKED: only `owner` is eligible; other requesters see `req_ready=0` even if the output is free.
    - On `load` with tail=1: go to IDLE.
    - `rr_ptr` does not change while LOCKED.
- **Outputs**:
  - `grant_id` updates to the winner on every `load` and otherwise holds.
  - `locked = (state == LOCKED)`.
- **Boundary cases**:
  - Wrap: when `rr_ptr == NUM_REQ-1`, the next value is 0.
  - Owner deasserts `req_valid` mid-packet: stay LOCKED and issue no grants; there is no timeout.
  - Output full and `put_flit_ready=0`: no `load`, all `req_ready=0`, and the arbiter state does not change.
  - Output full and `put_flit_ready=1` with a winner present: the register drains and reloads in the same cycle (full throughput).
  - Reset mid-packet: the lock is dropped and any buffered flit is discarded. Upstream must restart the packet.
- Flit contents pass through unchanged; the arbiter does not inspect the valid bit (MSB) or the VC field.

## Timing
- Reset values: `put_flit_valid=0`, `put_flit=0`, `grant_id=0`, `locked=0`, `req_ready=0`, `rr_ptr=0`, state IDLE.
- Latency: a flit accepted in cycle N is presented on `put_flit` in cycle N+1.
- Throughput: 1 flit/cycle while `put_flit_ready` stays high.
- `req_ready` is combinational from `req_valid`, state and `put_flit_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- `put_flit`, `put_flit_valid`, `grant_id` and `locked` are registered.

## Configuration
- `ARB_PACKET_LOCK_EN` defined: packet locking operates exactly as described above.
- `ARB_PACKET_LOCK_EN` undefined:
  - The arbiter never enters LOCKED and `locked` is tied to 0.
  - Round-robin arbitration is per flit, ignoring `TAIL_BIT`; `rr_ptr` advances on every `load`.
  - Use this only when every packet is a single flit.

## Test plan
- Reset, then `req_valid=4'b1111` with single-flit packets and `put_flit_ready=1` → grants in order 0,1,2,3,0; `put_flit` carries each flit one cycle after its handshake.
- Requester 2 sends a 3-flit packet (tails 0,0,1) while requester 0 stays valid → `locked=1` for flits 1–2; requester 0 is granted only after the tail, then `rr_ptr=3`.
- Owner idles for 5 cycles mid-packet while the others are valid → no `req_ready` for 5 cycles, `locked` stays 1, then the packet resumes.
- `put_flit_ready=0` for 3 cycles with the output full → `put_flit` and `put_flit_valid` hold, all `req_ready=0`; when ready is released, streaming resumes at 1 flit/cycle.
- `NUM_REQ=3`, grant to requester 2 → the next scan starts at 0 (wrap).
- `RST_N` asserted for 1 cycle while LOCKED with the output full → `put_flit_valid=0` and `locked=0` the next cycle; a fresh packet from requester 1 is granted.
